// File: rtl/serial_word_receiver_pkg.sv
// Shared types for the serial word receiver: FSM state encoding and
// the shift-direction constants.
package serial_word_receiver_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_e;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_word_out_slot.sv
// Single-entry valid/ready holding register; a word loads one edge after word_done.
// A completing word that finds the slot full and unconsumed is dropped and sets sticky overrun.
module serial_word_out_slot
  import serial_word_receiver_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [DW-1:0] word,
  input  logic          word_done,
  output logic [DW-1:0] slot_dat,
  output logic          slot_vld,
  input  logic          slot_rdy,
  output logic          overrun,
  input  logic          overrun_clr
);

  logic [DW-1:0] dat_q, dat_d;
  logic          vld_q, vld_d;
  logic          ovr_q, ovr_d;
  logic          xfer;

  always_comb begin
    dat_d = dat_q;
    vld_d = vld_q;
    ovr_d = ovr_q;
    xfer  = ena && vld_q && slot_rdy;
    if (ena) begin
      if (overrun_clr) ovr_d = 1'b0;
      // A consume on the same edge frees the slot for the incoming word.
      if (word_done) begin
        if (!vld_q || xfer) begin
          dat_d = word;
          vld_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else if (xfer) begin
        vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dat_q <= '0;
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      dat_q <= dat_d;
      vld_q <= vld_d;
      ovr_q <= ovr_d;
    end
  end

  assign slot_dat = dat_q;
  assign slot_vld = vld_q;
  assign overrun  = ovr_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Framed serial-to-parallel receiver; word valid one cycle after the last captured bit; stalled consumer drops words (overrun).
// Optional even-parity trailer bit and parity_err output under SERIAL_WORD_RECEIVER_PARITY_EN.
module serial_word_receiver
  import serial_word_receiver_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             sdi,
  input  logic             sdi_valid,
  input  logic             start,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
  output logic             parity_err,
`endif
  input  logic             overrun_clr
);

`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int              FRAME_LEN = WIDTH + PAR_BITS;
  localparam int              SLOT_W    = WIDTH + PAR_BITS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic [CNT_W-1:0]  idx;
  logic              dir_eff;
  logic [WIDTH-1:0]  sr_base;
  logic [WIDTH-1:0]  sr_shift;
  logic              capture;
  logic              word_done;
  logic [SLOT_W-1:0] word;
  logic [SLOT_W-1:0] slot_dat;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
  logic              par_q, par_d;
  logic              par_base;
`endif

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    word_done = 1'b0;
    // A start marker restarts the frame, so the same-cycle bit sees a clean base.
    idx       = start ? '0 : cnt_q;
    dir_eff   = start ? lsb_first : dir_q;
    sr_base   = start ? '0 : sr_q;
    sr_shift  = (dir_eff == DIR_LSB_FIRST) ? {sdi, sr_base[WIDTH-1:1]}
                                           : {sr_base[WIDTH-2:0], sdi};
    capture   = sdi_valid && (start || (state_q == ST_RECV));
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    par_d     = par_q;
    par_base  = start ? 1'b0 : par_q;
    // Trailer bit is not shifted in; the running XOR of all frame bits is the error flag.
    word      = {par_base ^ sdi, sr_base};
`else
    word      = sr_shift;
`endif
    if (ena) begin
      if (start) begin
        state_d = ST_RECV;
        dir_d   = lsb_first;
        cnt_d   = '0;
        sr_d    = '0;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        par_d   = 1'b0;
`endif
      end
      if (capture) begin
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        if (idx != LAST_IDX) sr_d = sr_shift;
        par_d = par_base ^ sdi;
`else
        sr_d = sr_shift;
`endif
        if (idx == LAST_IDX) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          word_done = 1'b1;
        end else begin
          cnt_d = idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_MSB_FIRST;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  serial_word_out_slot #(
    .DW(SLOT_W)
  ) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .word       (word),
    .word_done  (word_done),
    .slot_dat   (slot_dat),
    .slot_vld   (data_valid),
    .slot_rdy   (data_ready),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
  assign {parity_err, data_out} = slot_dat;
`else
  assign data_out = slot_dat;
`endif
  assign busy    = (state_q == ST_RECV);
  assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Scoreboarded random + directed bench for serial_word_receiver (WIDTH=4);
// a bit-list reference model predicts the slot contents, overrun and framing outputs.
module tb_serial_word_receiver;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic          sdi = 1'b0;
  logic          sdi_valid = 1'b0;
  logic          start = 1'b0;
  logic          lsb_first = 1'b0;
  logic          data_ready = 1'b0;
  logic          overrun_clr = 1'b0;
  logic [W-1:0]  data_out;
  logic          data_valid;
  logic          busy;
  logic [CW-1:0] bit_cnt;
  logic          overrun;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
  logic          parity_err;
`endif

  serial_word_receiver #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .sdi        (sdi),
    .sdi_valid  (sdi_valid),
    .start      (start),
    .lsb_first  (lsb_first),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .bit_cnt    (bit_cnt),
    .overrun    (overrun),
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    .parity_err (parity_err),
`endif
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] word;
    logic         perr;
  } exp_t;

  exp_t         exp_q[$];
  bit           m_active = 1'b0;
  bit           m_bits[$];
  bit           m_dir = 1'b0;
  bit           m_full = 1'b0;
  logic [W-1:0] m_dout = '0;
  bit           m_perr = 1'b0;
  bit           m_ovr = 1'b0;
  int           total = 0;
  int           bad = 0;
  bit           stim_done = 1'b0;

  // Reference model: collect frame bits in a list, build the word arithmetically on completion.
  always @(posedge clk) begin : model
    bit           done;
    bit           consumed;
    bit           pe;
    logic [W-1:0] w;
    if (!rst_n) begin
      m_active = 1'b0;
      m_bits.delete();
      m_dir  = 1'b0;
      m_full = 1'b0;
      m_dout = '0;
      m_perr = 1'b0;
      m_ovr  = 1'b0;
      exp_q.delete();
    end else if (ena) begin
      consumed = m_full && data_ready;
      done = 1'b0;
      pe   = 1'b0;
      w    = '0;
      if (start) begin
        m_active = 1'b1;
        m_bits.delete();
        m_dir = lsb_first;
      end
      if (sdi_valid && m_active) begin
        m_bits.push_back(sdi);
        if (m_bits.size() == FL) begin
          for (int i = 0; i < W; i++) begin
            if (m_dir) w[i] = m_bits[i];
            else       w[W-1-i] = m_bits[i];
          end
          for (int i = 0; i < FL; i++) pe = pe ^ m_bits[i];
          done = 1'b1;
          m_active = 1'b0;
          m_bits.delete();
        end
      end
      if (overrun_clr) m_ovr = 1'b0;
      if (done) begin
        if (!m_full || consumed) begin
          m_full = 1'b1;
          m_dout = w;
          m_perr = pe;
          exp_q.push_back('{w, pe});
        end else begin
          m_ovr = 1'b1;
        end
      end else if (consumed) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, want, $time);
    end
  endtask

  // Monitor: per-cycle output checks plus scoreboard pop on every handshake.
  initial begin : monitor
    exp_t e;
    while (!stim_done) begin
      @(negedge clk);
      chk("data_valid", 32'(data_valid), 32'(m_full));
      chk("data_out", 32'(data_out), 32'(m_dout));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("busy", 32'(busy), 32'(m_active));
      chk("bit_cnt", 32'(bit_cnt), 32'(m_bits.size()));
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
      chk("parity_err", 32'(parity_err), 32'(m_perr));
`endif
      if (rst_n && ena && data_valid && data_ready) begin
        chk("xfer_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("xfer_word", 32'(data_out), 32'(e.word));
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
          chk("xfer_perr", 32'(parity_err), 32'(e.perr));
`endif
        end
      end
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic tick(input logic st, input logic v, input logic b);
    start     = st;
    sdi_valid = v;
    sdi       = b;
    @(posedge clk);
    #2;
    start     = 1'b0;
    sdi_valid = 1'b0;
  endtask

  // seq[0] is sent first; rdy_last is driven only on the completing bit.
  task automatic send(input logic lsb, input logic [7:0] seq, input bit gap,
                      input bit bad_par, input logic rdy_last);
    lsb_first = lsb;
    for (int i = 0; i < FL; i++) begin
      logic b;
      if (i < W) b = seq[i];
      else       b = (^seq[W-1:0]) ^ bad_par;
      if (i == FL - 1) data_ready = rdy_last;
      tick(i == 0, 1'b1, b);
      if (gap && i != FL - 1) tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic consume();
    data_ready = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    data_ready = 1'b0;
  endtask

  initial begin : stim
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0);

    send(1'b0, 8'b1101, 1'b0, 1'b0, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    consume();
    send(1'b1, 8'b1101, 1'b1, 1'b0, 1'b0);
    consume();

    send(1'b0, 8'b0101, 1'b0, 1'b0, 1'b0);
    send(1'b0, 8'b1010, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    overrun_clr = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    overrun_clr = 1'b0;
    consume();

    send(1'b0, 8'b0011, 1'b0, 1'b0, 1'b0);
    send(1'b0, 8'b1100, 1'b0, 1'b0, 1'b1);
    data_ready = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    consume();

    lsb_first = 1'b0;
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    send(1'b0, 8'b0110, 1'b0, 1'b0, 1'b0);
    consume();

    lsb_first = 1'b1;
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    send(1'b1, 8'b1001, 1'b0, 1'b0, 1'b0);
    consume();

    lsb_first = 1'b0;
    tick(1'b1, 1'b1, 1'b1);
    ena = 1'b0;
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    ena = 1'b1;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    tick(1'b0, 1'b1, 1'b1);
    consume();
    send(1'b0, 8'b1101, 1'b0, 1'b0, 1'b0);
    consume();
    send(1'b0, 8'b1101, 1'b0, 1'b1, 1'b0);
`endif
    consume();

    for (int n = 0; n < 4000; n++) begin
      rst_n       = ($urandom_range(0, 499) != 0);
      ena         = ($urandom_range(0, 9) != 0);
      lsb_first   = 1'($urandom_range(0, 1));
      data_ready  = 1'($urandom_range(0, 1));
      overrun_clr = ($urandom_range(0, 19) == 0);
      tick(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)));
    end

    rst_n       = 1'b1;
    ena         = 1'b1;
    overrun_clr = 1'b0;
    data_ready  = 1'b1;
    repeat (10) tick(1'b0, 1'b0, 1'b0);
    stim_done = 1'b1;
  end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Serial-in/parallel-out receiver: the receiving end of the serial stream produced by the 4-bit universal shift register's shift-left/shift-right modes.
- Reassembles a framed serial bit stream into WIDTH-bit words.
- Presents each word on a valid/ready output handshake.
- Flags overruns when the consumer stalls.

Parameters:
- WIDTH, 4, data bits per frame (>= 2).
- CNT_W, $clog2(WIDTH+1), width of the bit counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  global enable; 0 freezes all state (reset still acts)
- sdi  in  1  serial data bit
- sdi_valid  in  1  sdi is valid this cycle
- start  in  1  frame start marker
- lsb_first  in  1  1: first bit is data[0]; 0: first bit is data[WIDTH-1]; sampled at start, held for the frame
- data_out  out  WIDTH  received word
- data_valid  out  1  data_out holds an unconsumed word
- data_ready  in  1  consumer accepts data_out when data_valid=1
- busy  out  1  frame in progress
- bit_cnt  out  CNT_W  bits captured in current frame
- overrun  out  1  sticky: a completed word was dropped
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset values (rst_n=0 at posedge clk): state=IDLE, shift reg=0, data_out=0, data_valid=0, busy=0, bit_cnt=0, overrun=0, dir latch=0. Reset overrides ena and aborts any frame.
- ena=0: no state changes. Handshake inputs are ignored.
- FSM states:
  - IDLE: sdi_valid without start is ignored. start=1 -> RECV, latch lsb_first, bit_cnt=0. If sdi_valid=1 in the same cycle, that bit is captured as bit 0 and bit_cnt=1.
  - RECV: each sdi_valid cycle captures one bit and increments bit_cnt.
    - MSB-first: sr <= {sr[WIDTH-2:0], sdi}.
    - LSB-first: sr <= {sdi, sr[WIDTH-1:1]}.
  - start=1 in RECV: aborts the current frame and restarts it as in IDLE. Partial bits are discarded and overrun is unaffected.
  - Frame completion: when the WIDTH-th bit is captured, the FSM moves to IDLE, sets busy=0 and bit_cnt=0. The assembled word, including the final bit, is offered to the output slot in that same edge.
- Output slot: the word appears on data_out with data_valid=1 one cycle after the clock edge that captured the last bit.
- Handshake:
  - A transfer occurs on a clock edge with data_valid=1, data_ready=1 and ena=1.
  - data_out is stable while data_valid=1 and no transfer occurs.
  - After a transfer, data_valid drops unless a new word completes on the same edge. In that case the new word loads and data_valid stays 1.
- Overrun: the slot is occupied (data_valid=1) and not being consumed on the edge where a word completes. Required response:
  - The new word is dropped; data_out keeps the old word.
  - overrun is set to 1.
- overrun_clr: clears overrun. If an overrun event happens on the same edge, set wins.
- busy=1 exactly while the FSM is in RECV.

Optional Feature:
- Macro: SERIAL_WORD_RECEIVER_PARITY_EN.
- When defined:
  - Each frame carries one extra bit after the WIDTH data bits: an even-parity bit, such that XOR of the data bits and the parity bit is 0.
  - The frame completes on the parity bit.
  - Adds output port parity_err (1 bit). It is updated on each word load to the slot: 1 if parity mismatched, else 0. It is held with data_out, and its reset value is 0.
  - The counter range extends to WIDTH+1.
- When undefined: no parity bit, no parity_err port; behaviour as above.

Decomposition:
- Package serial_word_receiver_pkg:
  - State enum (ST_IDLE, ST_RECV).
  - Direction constants DIR_MSB_FIRST=0 and DIR_LSB_FIRST=1.
- One sub-module: serial_word_out_slot, a single-entry valid/ready holding register with overrun detection, driven by the FSM's word/word_done outputs.

Test Plan (WIDTH=4):
- MSB-first: start+bits 1,0,1,1 on 4 consecutive cycles -> next cycle data_out=4'b1011, data_valid=1, busy=0. data_ready=1 -> data_valid=0 after one edge.
- LSB-first: same bits 1,0,1,1 -> data_out=4'b1101. Bits spaced with sdi_valid=0 gaps -> same result, bit_cnt steps 1..3 then 0.
- Back-to-back words with data_ready held at 0: word A=4'hA accepted in slot, word B=4'h5 completes -> data_out stays 4'hA, overrun=1. overrun_clr -> overrun=0.
- Simultaneous consume and complete: data_ready=1 on the edge word 4'h3 completes while 4'hC is in the slot -> data_out=4'h3, data_valid=1, overrun=0.
- Restart and reset:
  - start after 2 bits, then 4 bits 0,1,1,0 -> data_out=4'h6.
  - rst_n=0 mid-frame -> all outputs 0, the following frame decodes correctly.
  - ena=0 for 3 cycles mid-frame -> bits on those cycles are ignored, the frame resumes.
- Parity (macro defined): data 1,0,1,1 + parity 1 -> data_out=4'hB, parity_err=0. With parity 0 -> parity_err=1.
